// File: rtl/chaos_key_gen.sv
// chaos_key_gen: iterates a 4-D hyperchaotic Lorenz-type system in Q8.24
// fixed point and presents one byte of each state variable as a key byte.
// A single shared 32x32 multiplier is time-multiplexed over three product
// states, then all four state variables are updated together.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a rising edge on chaos_step; outputs are stable
//   M_XZ  | multiplier computes x*z, result registered
//   M_XY  | multiplier computes x*y, result registered
//   M_YZ  | multiplier computes y*z, result registered
//   UPD   | derivatives formed, x/y/z/w and output bytes updated
module chaos_key_gen #(
    parameter int         OUT_LSB   = 16,
    parameter logic [4:0] DEFAULT_K = 5'd8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        chaos_reset,
    input  logic        chaos_step,
    input  logic [31:0] chaos_shift,
    output logic [7:0]  chaos_x,
    output logic [7:0]  chaos_y,
    output logic [7:0]  chaos_z,
    output logic [7:0]  chaos_w,
    output logic        chaos_done
);

    localparam logic signed [31:0] ONE = 32'sh0100_0000;

    typedef enum logic [2:0] {
        IDLE,
        M_XZ,
        M_XY,
        M_YZ,
        UPD
    } state_t;

    state_t             st;
    logic signed [31:0] x, y, z, w;
    logic [4:0]         k;
    logic               step_d;
    logic signed [31:0] p_xz, p_xy, p_yz;

    logic signed [31:0] mul_a, mul_b;
    logic signed [63:0] mul_a64, mul_b64, prod;
    logic signed [31:0] prod_q;

    logic signed [31:0] diff_yx;
    logic signed [31:0] dx, dy, dz, dw;
    logic signed [31:0] nx, ny, nz, nw;
    logic signed [31:0] seed_x;

    logic               unused_bits;

    // Select the operand pair for the shared multiplier from the FSM state.
    always_comb begin
        mul_a = x;
        mul_b = z;
        case (st)
            M_XY: begin
                mul_a = x;
                mul_b = y;
            end
            M_YZ: begin
                mul_a = y;
                mul_b = z;
            end
            default: begin
                mul_a = x;
                mul_b = z;
            end
        endcase
    end

    // Full-width signed product; the Q8.24 result is bits [55:24].
    assign mul_a64 = {{32{mul_a[31]}}, mul_a};
    assign mul_b64 = {{32{mul_b[31]}}, mul_b};
    assign prod    = mul_a64 * mul_b64;
    assign prod_q  = prod[55:24];

    // Derivatives with constant multiplies as shift/add; everything wraps.
    always_comb begin
        diff_yx = y - x;
        dx = (diff_yx <<< 3) + (diff_yx <<< 1) + w;
        dy = (x <<< 5) - (x <<< 2) - y - p_xz;
        dz = p_xy - ((z <<< 1) + z);
        dw = 32'sd0 - p_yz - w;
        nx = x + (dx >>> k);
        ny = y + (dy >>> k);
        nz = z + (dz >>> k);
        nw = w + (dw >>> k);
    end

    assign seed_x = {8'h01, chaos_shift[31:8]};

    // Bits [7:5] of the shift word and the discarded product bits are unused.
    assign unused_bits = ^{chaos_shift[7:5], prod[63:56], prod[23:0]};

    // Sequencer, state registers and registered key bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            st         <= IDLE;
            x          <= ONE;
            y          <= ONE;
            z          <= ONE;
            w          <= ONE;
            k          <= DEFAULT_K;
            step_d     <= 1'b0;
            p_xz       <= '0;
            p_xy       <= '0;
            p_yz       <= '0;
            chaos_x    <= 8'h00;
            chaos_y    <= 8'h00;
            chaos_z    <= 8'h00;
            chaos_w    <= 8'h00;
            chaos_done <= 1'b0;
        end else begin
            step_d <= chaos_step;
            if (chaos_reset) begin
                // Seed load wins over everything and abandons any iteration.
                st         <= IDLE;
                x          <= seed_x;
                y          <= ONE;
                z          <= ONE;
                w          <= ONE;
                k          <= chaos_shift[4:0];
                chaos_x    <= seed_x[OUT_LSB +: 8];
                chaos_y    <= ONE[OUT_LSB +: 8];
                chaos_z    <= ONE[OUT_LSB +: 8];
                chaos_w    <= ONE[OUT_LSB +: 8];
                chaos_done <= 1'b0;
            end else begin
                case (st)
                    IDLE: begin
                        if (chaos_step && !step_d) begin
                            k          <= chaos_shift[4:0];
                            chaos_done <= 1'b0;
                            st         <= M_XZ;
                        end
                    end
                    M_XZ: begin
                        p_xz <= prod_q;
                        st   <= M_XY;
                    end
                    M_XY: begin
                        p_xy <= prod_q;
                        st   <= M_YZ;
                    end
                    M_YZ: begin
                        p_yz <= prod_q;
                        st   <= UPD;
                    end
                    UPD: begin
                        x          <= nx;
                        y          <= ny;
                        z          <= nz;
                        w          <= nw;
                        chaos_x    <= nx[OUT_LSB +: 8];
                        chaos_y    <= ny[OUT_LSB +: 8];
                        chaos_z    <= nz[OUT_LSB +: 8];
                        chaos_w    <= nw[OUT_LSB +: 8];
                        chaos_done <= 1'b1;
                        st         <= IDLE;
                    end
                    default: begin
                        st <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: doc/chaos_key_gen.md
# chaos_key_gen

Hardware end of the Nios chaos-key PIO link: iterates a 4-D hyperchaotic Lorenz-type system in Q8.24 fixed point and returns four 8-bit key bytes.
- The processor drives `chaos_reset` (seed load), `chaos_step` (iteration request) and `chaos_shift` (seed / step size).
- The block answers with `chaos_x/y/z/w` and `chaos_done`.
- It sits beside the Qsys system, on the same clock, wired port-for-port to the PIO exports.

## Interface
Parameters:
- `OUT_LSB`, 16: LSB index of the state slice presented on each 8-bit output (`state[OUT_LSB+7:OUT_LSB]`).
- `DEFAULT_K`, 8: step-size shift used after `reset`.

Ports:
- `clk`  in  1  system clock; every input is synchronous to it.
- `reset`  in  1  synchronous, active-high global reset.
- `chaos_reset`  in  1  level; load the seed while high.
- `chaos_step`  in  1  a rising edge requests one iteration.
- `chaos_shift`  in  32  `[31:8]` seed fraction for x; `[4:0]` dt shift k; `[7:5]` ignored.
- `chaos_x`, `chaos_y`, `chaos_z`, `chaos_w`  out  8 each  key bytes, registered.
- `chaos_done`  out  1  high means the outputs hold the result of the latest iteration.

## Operation
State:
- x, y, z, w are 32-bit signed Q8.24 values; 1.0 = 0x0100_0000.
- k is a 5-bit shift.
- `step_d` is the registered previous value of `chaos_step`.

Equations, with a=10, b=3, c=28:
- dx = 10(y−x) + w
- dy = 28x − y − xz
- dz = xy − 3z
- dw = −yz − w
- Next state: v ← v + (dv >>> k), arithmetic shift, for each of x, y, z, w.

Arithmetic rules:
- Constants are implemented as shift/add; there is no multiplier for constants.
- Products use one shared signed 32×32 multiplier. The result is bits [55:24] of the 64-bit product.
- All adds, subtracts and truncations wrap in two's complement. There is no saturation.

FSM states: IDLE, M_XZ, M_XY, M_YZ, UPD.
- IDLE: on `chaos_step`=1 and `step_d`=0, latch k ← `chaos_shift[4:0]`, clear `chaos_done`, go to M_XZ.
- M_XZ: register xz; go to M_XY.
- M_XY: register xy; go to M_YZ.
- M_YZ: register yz; go to UPD.
- UPD: compute the derivatives from the current state and the registered products, then update x, y, z, w simultaneously. Update the output bytes from the new state, set `chaos_done`=1, go to IDLE.

Control rules:
- `step_d` updates every cycle. A rising edge that arrives while the FSM is not in IDLE is dropped.
- A step held high produces exactly one iteration.
- `chaos_reset`=1 in any state (priority over step):
  - load x = {8'h01, `chaos_shift[31:8]`}, y = z = w = 0x0100_0000;
  - load k = `chaos_shift[4:0]`;
  - go to IDLE and clear `chaos_done`;
  - set outputs: `chaos_x` = slice of the new x, the others = slice of 1.0.
  - An in-flight iteration is discarded.
- `reset`: x = y = z = w = 1.0, k = `DEFAULT_K`, FSM IDLE, `step_d`=0, `chaos_done`=0, all outputs 8'h00.
- k=0 is legal: the full derivative is added and the result wraps.

## Timing
- Edge accepted at clock edge N (step sampled 1, `step_d` sampled 0).
- M_XZ, M_XY, M_YZ and UPD occupy cycles N+1 to N+4.
- New outputs and `chaos_done`=1 are visible after edge N+4, i.e. 4 cycles after acceptance.
- `chaos_done` falls at edge N (the acceptance edge). It stays high between iterations.
- Minimum step period: step must return low for at least 1 cycle, then a new edge may be accepted in the cycle after UPD.
- Seed-load latency is 1 cycle: outputs and state reflect `chaos_shift` on the cycle after `chaos_reset` is sampled high.
- Outputs change only in UPD, on `chaos_reset`, or on `reset`.

## Test plan
- Reset: assert `reset` 2 cycles → all outputs 0x00, `chaos_done`=0; a step edge while `reset` is high is ignored.
- Single iteration: `chaos_shift`=0x0000_0008, pulse `chaos_reset`, then a step edge → 4 cycles after acceptance: x=0x0101_0000, y=0x011A_0000, z=0x00FE_0000, w=0x00FE_0000; outputs 0x01/0x1A/0xFE/0xFE; `chaos_done`=1.
- Seed load: `chaos_shift`=0xAB00_0008 with `chaos_reset` high → `chaos_x`=0xAB, others 0x00, `chaos_done`=0.
- Step handshake: hold step high 20 cycles → exactly one iteration; a second edge during M_XY is dropped; 1000 back-to-back iterations match the bit-exact C model.
- Abort: assert `chaos_reset` during M_YZ → no UPD occurs, `chaos_done` stays 0, state equals the seed.
- Wrap: k=0 with large seed x=0x01FF_FFFF → state wraps without saturation and matches the model bit-exactly over 50 steps.
